// File: rtl/img_top_pkg.sv
// Shared pixel-bus types for the image pipeline, plus the background-model
// state encoding and the per-pixel running-average update used by bg_model_update.
package img_top_pkg;

    localparam int PCLK  = 4;
    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [PCLK-1:0]  pix_bus_t;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_TRACK = 1'b1
    } bg_state_e;

    // Exponential moving average step: bg + floor((img - bg) / 2^shift).
    // The result always lies between bg and img, so truncation to PIX_W is exact.
    function automatic pix_t ema_update(input pix_t bg, input pix_t img, input int shift);
        logic signed [PIX_W:0] diff;
        logic signed [PIX_W:0] step;
        logic signed [PIX_W:0] sum;
        diff = $signed({1'b0, img}) - $signed({1'b0, bg});
        step = diff >>> shift;
        sum  = $signed({1'b0, bg}) + step;
        return sum[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/bg_frame_ram.sv
// Simple dual-port frame store for the background model: one write port,
// one read port with a registered (1-cycle) output. Read-before-write on a
// same-address collision; the caller is responsible for forwarding.
module bg_frame_ram
    import img_top_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  pix_bus_t          wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output pix_bus_t          rd_data
);

    pix_bus_t mem [DEPTH];

    // Write port: store one beat of background pixels.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered output, holds its value when not enabled.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bg_model_update.sv
// Running-average background model. Passes the image through with one cycle
// of latency and serves the co-aligned background beat, learning the first
// frame verbatim and then tracking with an EMA of rate 2^-ALPHA_SHIFT.
// Optional feature macro: BG_FREEZE_EN adds a freeze input that suppresses
// background writes for beats accepted in S_TRACK.
module bg_model_update
    import img_top_pkg::*;
#(
    parameter int FRAME_PIX   = 76800,
    parameter int ALPHA_SHIFT = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    input  pix_bus_t img_in,
    input  logic     in_valid,
    input  logic     sof,
    output pix_bus_t img_out,
    output pix_bus_t bg_out,
    output logic     out_valid,
    output logic     bg_ready
`ifdef BG_FREEZE_EN
    ,
    input  logic     freeze
`endif
);

    localparam int FRAME_WORDS = FRAME_PIX / PCLK;
    localparam int ADDR_W      = $clog2(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    bg_state_e         state_q;
    bg_state_e         state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] beat_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              beat_write;

    logic [ADDR_W-1:0] out_addr_q;
    logic              out_init_q;
    logic              out_wr_q;
    logic              fwd_valid_q;
    pix_bus_t          fwd_data_q;

    pix_bus_t          rd_data;
    pix_bus_t          bg_cur;
    pix_bus_t          bg_new;
    pix_bus_t          wr_data;
    logic              wr_en;

    // Beat addressing: sof (or the natural wrap) puts the beat at word 0.
    always_comb begin
        beat_addr = sof ? '0 : addr_q;
        next_addr = (beat_addr == LAST_ADDR) ? '0 : beat_addr + ADDR_W'(1);
    end

    // Decide whether the incoming beat may update the stored background.
`ifdef BG_FREEZE_EN
    always_comb begin
        beat_write = !(freeze && (state_q == S_TRACK));
    end
`else
    always_comb begin
        beat_write = 1'b1;
    end
`endif

    // Next state: learning ends once the last word of a frame is accepted.
    always_comb begin
        state_d = state_q;
        if (in_valid && (state_q == S_INIT) && (beat_addr == LAST_ADDR)) begin
            state_d = S_TRACK;
        end
    end

    // State and frame address registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (in_valid) begin
                addr_q <= next_addr;
            end
        end
    end

    // Output-stage registers: delayed image, per-beat context and write forwarding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            img_out     <= '0;
            out_init_q  <= 1'b1;
            out_addr_q  <= '0;
            out_wr_q    <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
            bg_ready    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                img_out     <= img_in;
                out_init_q  <= (state_q == S_INIT);
                out_addr_q  <= beat_addr;
                out_wr_q    <= beat_write;
                fwd_valid_q <= wr_en && (out_addr_q == beat_addr);
                fwd_data_q  <= wr_data;
                if (state_d == S_TRACK) begin
                    bg_ready <= 1'b1;
                end
            end
        end
    end

    // Background selection, EMA update and write-back data for the beat on the outputs.
    always_comb begin
        bg_cur = fwd_valid_q ? fwd_data_q : rd_data;
        bg_new = '0;
        for (int p = 0; p < PCLK; p++) begin
            bg_new[p] = ema_update(bg_cur[p], img_out[p], ALPHA_SHIFT);
        end
        wr_data = out_init_q ? img_out : bg_new;
        bg_out  = out_init_q ? img_out : bg_cur;
        wr_en   = out_valid && out_wr_q && rst_n;
    end

    bg_frame_ram #(
        .DEPTH  (FRAME_WORDS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (out_addr_q),
        .wr_data (wr_data),
        .rd_en   (in_valid),
        .rd_addr (beat_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_bg_model_update.sv
// Testbench for bg_model_update with an 8-word frame and ALPHA_SHIFT=2.
// Exercises the freeze input only when BG_FREEZE_EN is defined.
module tb_bg_model_update;
    import img_top_pkg::*;

    localparam int FW    = 8;
    localparam int ALPHA = 2;

    logic     clk = 1'b0;
    logic     rst_n;
    pix_bus_t img_in;
    logic     in_valid;
    logic     sof;
    logic     freeze;
    pix_bus_t img_out;
    pix_bus_t bg_out;
    logic     out_valid;
    logic     bg_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: background per word/lane, learn flag, frame pointer.
    int       bg_ref [FW][PCLK];
    bit       learned;
    int       maddr;
    logic     exp_valid;
    pix_bus_t exp_img;
    pix_bus_t exp_bg;
    logic     exp_ready;

    bg_model_update #(
        .FRAME_PIX   (FW * PCLK),
        .ALPHA_SHIFT (ALPHA)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .img_in    (img_in),
        .in_valid  (in_valid),
        .sof       (sof),
        .img_out   (img_out),
        .bg_out    (bg_out),
        .out_valid (out_valid),
        .bg_ready  (bg_ready)
`ifdef BG_FREEZE_EN
        ,
        .freeze    (freeze)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic int floor_step(input int d);
        int q;
        q = 1 << ALPHA;
        if (d >= 0) return d / q;
        return -((-d + q - 1) / q);
    endfunction

    function automatic pix_bus_t fill(input int v);
        pix_bus_t r;
        for (int p = 0; p < PCLK; p++) r[p] = PIX_W'(v);
        return r;
    endfunction

    function automatic pix_bus_t rand_bus();
        pix_bus_t r;
        for (int p = 0; p < PCLK; p++) r[p] = PIX_W'($urandom_range(0, 255));
        return r;
    endfunction

    // Drive one cycle of input, advance the model, and land 1 time unit after the edge.
    task automatic applyStimulus(input pix_bus_t img, input bit v, input bit s, input bit frz);
        int  a;
        bit  frz_eff;
`ifdef BG_FREEZE_EN
        frz_eff = frz;
`else
        frz_eff = 1'b0;
`endif
        img_in   = img;
        in_valid = v;
        sof      = s;
        freeze   = frz;
        if (v) begin
            a = s ? 0 : maddr;
            for (int p = 0; p < PCLK; p++) begin
                if (!learned) begin
                    exp_bg[p]    = img[p];
                    bg_ref[a][p] = int'(img[p]);
                end else begin
                    exp_bg[p] = PIX_W'(bg_ref[a][p]);
                    if (!frz_eff)
                        bg_ref[a][p] = bg_ref[a][p] + floor_step(int'(img[p]) - bg_ref[a][p]);
                end
            end
            if (!learned && a == FW - 1) learned = 1'b1;
            maddr     = (a == FW - 1) ? 0 : a + 1;
            exp_img   = img;
            exp_ready = learned;
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sof      = 1'b0;
        freeze   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sof      = 1'b0;
        freeze   = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        learned   = 1'b0;
        maddr     = 0;
        exp_valid = 1'b0;
        exp_img   = '0;
        exp_bg    = '0;
        exp_ready = 1'b0;
    endtask

    task automatic test_reset();
        img_in = fill(77);
        do_reset();
        tests_run++;
        if (out_valid !== 1'b0 || img_out !== '0 || bg_out !== '0 || bg_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset: valid/img/bg/ready got %b/%h/%h/%b want 0/0/0/0",
                     out_valid, img_out, bg_out, bg_ready);
        end
    endtask

    task automatic test_learn();
        do_reset();
        for (int b = 0; b < FW + 1; b++) begin
            if (b == 4) applyStimulus(fill(100), 1'b0, 1'b0, 1'b0);
            else        applyStimulus(fill(100), 1'b1, b == 0, 1'b0);
            tests_run++;
            if (out_valid !== exp_valid || img_out !== exp_img || bg_out !== exp_bg || bg_ready !== exp_ready) begin
                tests_failed++;
                $display("[TB] FAIL learn beat %0d: valid/img/bg/ready got %b/%h/%h/%b want %b/%h/%h/%b",
                         b, out_valid, img_out, bg_out, bg_ready, exp_valid, exp_img, exp_bg, exp_ready);
            end
        end
    endtask

    task automatic test_track();
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < FW; b++) begin
                applyStimulus(fill(140), 1'b1, b == 0, 1'b0);
                tests_run++;
                if (out_valid !== exp_valid || img_out !== exp_img || bg_out !== exp_bg || bg_ready !== exp_ready) begin
                    tests_failed++;
                    $display("[TB] FAIL track f%0d b%0d: valid/img/bg/ready got %b/%h/%h/%b want %b/%h/%h/%b",
                             f, b, out_valid, img_out, bg_out, bg_ready, exp_valid, exp_img, exp_bg, exp_ready);
                end
                if (f == 1) begin
                    tests_run++;
                    if (bg_out !== fill(110)) begin
                        tests_failed++;
                        $display("[TB] FAIL track_const b%0d: bg got %h want %h", b, bg_out, fill(110));
                    end
                end
            end
        end
    endtask

    task automatic test_extremes();
        pix_bus_t img;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < FW; b++) begin
                img = rand_bus();
                if (f == 0) begin img[0] = 8'd100; img[1] = 8'd255; end
                if (f == 1) begin img[0] = 8'd97;  img[1] = 8'd0;   end
                applyStimulus(img, 1'b1, b == 0, 1'b0);
                tests_run++;
                if (out_valid !== exp_valid || img_out !== exp_img || bg_out !== exp_bg || bg_ready !== exp_ready) begin
                    tests_failed++;
                    $display("[TB] FAIL extremes f%0d b%0d: valid/img/bg/ready got %b/%h/%h/%b want %b/%h/%h/%b",
                             f, b, out_valid, img_out, bg_out, bg_ready, exp_valid, exp_img, exp_bg, exp_ready);
                end
                if (f == 2) begin
                    tests_run++;
                    if (bg_out[0] !== 8'd99) begin
                        tests_failed++;
                        $display("[TB] FAIL extremes_floor b%0d: bg lane0 got %0d want 99", b, bg_out[0]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int b = 0; b < FW; b++) applyStimulus(fill(100), 1'b1, b == 0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(fill(140), 1'b1, b < 2, 1'b0);
            tests_run++;
            if (out_valid !== exp_valid || img_out !== exp_img || bg_out !== exp_bg || bg_ready !== exp_ready) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back b%0d: valid/img/bg/ready got %b/%h/%h/%b want %b/%h/%h/%b",
                         b, out_valid, img_out, bg_out, bg_ready, exp_valid, exp_img, exp_bg, exp_ready);
            end
            if (b == 1) begin
                tests_run++;
                if (bg_out !== fill(110)) begin
                    tests_failed++;
                    $display("[TB] FAIL back_to_back_fwd: bg got %h want %h", bg_out, fill(110));
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int b = 0; b < FW; b++) applyStimulus(fill(100), 1'b1, b == 0, 1'b0);
        for (int b = 0; b < FW; b++) applyStimulus(fill(140), 1'b1, b == 0, 1'b0);
        for (int b = 0; b < 3; b++) applyStimulus(fill(140), 1'b1, b == 0, 1'b0);
        do_reset();
        tests_run++;
        if (out_valid !== 1'b0 || bg_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: valid/ready got %b/%b want 0/0", out_valid, bg_ready);
        end
        for (int b = 0; b < FW; b++) begin
            applyStimulus(rand_bus(), 1'b1, b == 0, 1'b0);
            tests_run++;
            if (out_valid !== exp_valid || img_out !== exp_img || bg_out !== exp_bg || bg_ready !== exp_ready) begin
                tests_failed++;
                $display("[TB] FAIL mid_reset relearn b%0d: valid/img/bg/ready got %b/%h/%h/%b want %b/%h/%h/%b",
                         b, out_valid, img_out, bg_out, bg_ready, exp_valid, exp_img, exp_bg, exp_ready);
            end
        end
    endtask

`ifdef BG_FREEZE_EN
    task automatic test_freeze();
        do_reset();
        for (int b = 0; b < FW; b++) applyStimulus(fill(100), 1'b1, b == 0, 1'b0);
        for (int b = 0; b < FW; b++) applyStimulus(fill(140), 1'b1, b == 0, 1'b0);
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < FW; b++) begin
                applyStimulus(fill(200), 1'b1, b == 0, f == 0);
                tests_run++;
                if (out_valid !== exp_valid || img_out !== exp_img || bg_out !== exp_bg || bg_ready !== exp_ready) begin
                    tests_failed++;
                    $display("[TB] FAIL freeze f%0d b%0d: valid/img/bg/ready got %b/%h/%h/%b want %b/%h/%h/%b",
                             f, b, out_valid, img_out, bg_out, bg_ready, exp_valid, exp_img, exp_bg, exp_ready);
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        bit v;
        bit s;
        do_reset();
        for (int b = 0; b < 60; b++) begin
            v = ($urandom_range(0, 3) != 0);
            s = (b == 0) || ($urandom_range(0, 15) == 0);
            applyStimulus(rand_bus(), v, s, $urandom_range(0, 3) == 0);
            tests_run++;
            if (out_valid !== exp_valid || img_out !== exp_img || bg_out !== exp_bg || bg_ready !== exp_ready) begin
                tests_failed++;
                $display("[TB] FAIL random b%0d: valid/img/bg/ready got %b/%h/%h/%b want %b/%h/%h/%b",
                         b, out_valid, img_out, bg_out, bg_ready, exp_valid, exp_img, exp_bg, exp_ready);
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst_n    = 1'b0;
        img_in   = '0;
        in_valid = 1'b0;
        sof      = 1'b0;
        freeze   = 1'b0;
        test_reset();
        test_learn();
        test_track();
        test_extremes();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef BG_FREEZE_EN
        test_freeze();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
